writeback_stage: RTL

- MEM/WB pipeline register and write-back unit of the pipelined KGP-RISC core.
- Captures memory-stage results and selects the write-back value from ALU result, load data or link address.
- Drives the write port of the register bank.
- Provides same-cycle write-to-read bypass for decode-stage register reads: the register bank writes on the clock edge but reads combinationally.

---
 rtl/writeback_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// ============================================================================
// Module   : writeback_stage
// Purpose  : MEM/WB pipeline register, write-back select and decode bypass.
//            Optional retired-instruction counter under WB_RETIRE_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module writeback_stage #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int LINK_OFFSET = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              in_reg_write,
   input  logic [ADDR_W-1:0] in_dr,
   input  logic [1:0]        in_wb_sel,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_mem_data,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [ADDR_W-1:0] sr1,
   input  logic [ADDR_W-1:0] sr2,
   input  logic [DATA_W-1:0] rf_rData1,
   input  logic [DATA_W-1:0] rf_rData2,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_dr,
   output logic [DATA_W-1:0] rf_wrData,
   output logic [DATA_W-1:0] rd1_fwd,
   output logic [DATA_W-1:0] rd2_fwd,
   output logic              wb_valid,
   output logic [31:0]       retire_count
);

   localparam logic [DATA_W-1:0] c_link_off = DATA_W'(LINK_OFFSET);
   localparam logic [1:0]        c_sel_alu  = 2'b00;
   localparam logic [1:0]        c_sel_mem  = 2'b01;
   localparam logic [1:0]        c_sel_link = 2'b10;

   logic              valid_q,     valid_d;
   logic              reg_write_q, reg_write_d;
   logic [ADDR_W-1:0] dr_q,        dr_d;
   logic [1:0]        wb_sel_q,    wb_sel_d;
   logic [DATA_W-1:0] alu_q,       alu_d;
   logic [DATA_W-1:0] mem_q,       mem_d;
   logic [DATA_W-1:0] pc_q,        pc_d;

   // Flush only kills the control bits; data fields are left as they were.
   always_comb begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
      dr_d        = dr_q;
      wb_sel_d    = wb_sel_q;
      alu_d       = alu_q;
      mem_d       = mem_q;
      pc_d        = pc_q;
      if (flush) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
      end else if (!stall) begin
         valid_d     = in_valid;
         reg_write_d = in_reg_write;
         dr_d        = in_dr;
         wb_sel_d    = in_wb_sel;
         alu_d       = in_alu_result;
         mem_d       = in_mem_data;
         pc_d        = in_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         dr_q        <= '0;
         wb_sel_q    <= 2'b00;
         alu_q       <= '0;
         mem_q       <= '0;
         pc_q        <= '0;
      end else begin
         valid_q     <= valid_d;
         reg_write_q <= reg_write_d;
         dr_q        <= dr_d;
         wb_sel_q    <= wb_sel_d;
         alu_q       <= alu_d;
         mem_q       <= mem_d;
         pc_q        <= pc_d;
      end
   end

   // The reserved select code falls back to the ALU result silently.
   always_comb begin
      rf_wrData = alu_q;
      case (wb_sel_q)
         c_sel_alu:  rf_wrData = alu_q;
         c_sel_mem:  rf_wrData = mem_q;
         c_sel_link: rf_wrData = pc_q + c_link_off;
         default:    rf_wrData = alu_q;
      endcase
   end

   assign rf_write = valid_q & reg_write_q & (dr_q != '0);
   assign rf_dr    = dr_q;
   assign wb_valid = valid_q;

   // The bank reads combinationally before its write edge, so forward here.
   assign rd1_fwd = (rf_write && (rf_dr == sr1)) ? rf_wrData : rf_rData1;
   assign rd2_fwd = (rf_write && (rf_dr == sr2)) ? rf_wrData : rf_rData2;

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_q, retire_d;

   always_comb begin
      retire_d = retire_q;
      if (valid_q && !stall && !flush)
         retire_d = retire_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         retire_q <= '0;
      else
         retire_q <= retire_d;
   end

   assign retire_count = retire_q;
`else
   assign retire_count = '0;
`endif

endmodule

`default_nettype wire
